// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared types and constants for the sequential FP multiplier
package fp_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_NORM = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Result flag encoding {of, uf}; the two bits are never set together.
  localparam logic [1:0] FLAG_NONE = 2'b00;
  localparam logic [1:0] FLAG_UF   = 2'b01;
  localparam logic [1:0] FLAG_OF   = 2'b10;

  function automatic int bias_of(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/fp_shift_add_mul.sv
// rtl/fp_shift_add_mul.sv - iterative unsigned shift-add multiplier, one partial product per cycle
module fp_shift_add_mul #(
  parameter int N = 7
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] product,
  output logic           done
);

  localparam int CW = $clog2(N + 1);

  logic [2*N-1:0] mcand;
  logic [2*N-1:0] acc;
  logic [N-1:0]   mplier;
  logic [CW-1:0]  cnt;
  logic           busy;

  // done is registered so it pulses on the cycle after the last partial product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        mcand  <= {{N{1'b0}}, a};
        mplier <= b;
        acc    <= '0;
        cnt    <= '0;
        busy   <= 1'b1;
      end else if (busy) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        if (cnt == CW'(N - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign product = acc;

endmodule

// File: rtl/fp_mul_seq.sv
// rtl/fp_mul_seq.sv - sequential floating-point multiplier with valid/ready handshakes
module fp_mul_seq
  import fp_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 6,
  parameter int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] z,
  output logic         of,
  output logic         uf
);

  localparam int N  = MAN_W + 1;
  localparam int PW = 2 * N;
  localparam logic signed [EXP_W+1:0] BIAS_E = (EXP_W + 2)'(bias_of(EXP_W));
  localparam logic signed [EXP_W+1:0] E_MAX  = (EXP_W + 2)'((1 << EXP_W) - 1);

  state_t state, state_nxt;

  logic             sign_r;
  logic [EXP_W-1:0] ex_r, ey_r;
  logic [W-1:0]     z_r;
  logic [1:0]       flags_r;

  logic             start;
  logic [N-1:0]     sig_x, sig_y;
  logic [PW-1:0]    prod;
  logic             mul_done;

  logic                    hi;
  logic [MAN_W-1:0]        man;
  logic signed [EXP_W+1:0] e_sum;
  logic                    zero_op;
  logic [W-1:0]            res_z;
  logic [1:0]              res_flags;

  assign start = (state == S_IDLE) && in_valid;
  // Hidden bit is zero for a zero-exponent operand; the multiply still runs so latency is fixed.
  assign sig_x = {x[W-2 -: EXP_W] != '0, x[MAN_W-1:0]};
  assign sig_y = {y[W-2 -: EXP_W] != '0, y[MAN_W-1:0]};

  fp_shift_add_mul #(.N(N)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (sig_x),
    .b       (sig_y),
    .product (prod),
    .done    (mul_done)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (in_valid) state_nxt = S_MUL;
      S_MUL:  if (mul_done) state_nxt = S_NORM;
      S_NORM: state_nxt = S_DONE;
      S_DONE: if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    hi      = prod[PW-1];
    man     = hi ? prod[2*MAN_W -: MAN_W] : prod[2*MAN_W-1 -: MAN_W];
    e_sum   = $signed({2'b00, ex_r}) + $signed({2'b00, ey_r}) - BIAS_E
            + $signed({{(EXP_W + 1){1'b0}}, hi});
    zero_op = (ex_r == '0) || (ey_r == '0);
    res_z     = {sign_r, {(W - 1){1'b0}}};
    res_flags = FLAG_NONE;
    if (zero_op) begin
      res_flags = FLAG_NONE;
    end else if (e_sum >= E_MAX) begin
      res_z     = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      res_flags = FLAG_OF;
    end else if (e_sum[EXP_W+1] || (e_sum == '0)) begin
      res_flags = FLAG_UF;
    end else begin
      res_z = {sign_r, e_sum[EXP_W-1:0], man};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      sign_r  <= 1'b0;
      ex_r    <= '0;
      ey_r    <= '0;
      z_r     <= '0;
      flags_r <= FLAG_NONE;
    end else begin
      state <= state_nxt;
      if (start) begin
        sign_r <= x[W-1] ^ y[W-1];
        ex_r   <= x[W-2 -: EXP_W];
        ey_r   <= y[W-2 -: EXP_W];
      end
      if (state == S_NORM) begin
        z_r     <= res_z;
        flags_r <= res_flags;
      end
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign z         = z_r;
  assign of        = (flags_r == FLAG_OF);
  assign uf        = (flags_r == FLAG_UF);

endmodule

// File: tb/tb_fp_mul_seq.sv
// tb/tb_fp_mul_seq.sv - directed self-checking bench for fp_mul_seq
module tb_fp_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] x = '0;
  logic [11:0] y = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] z;
  logic        of;
  logic        uf;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [11:0] x;
    logic [11:0] y;
    logic [11:0] z;
    logic        of;
    logic        uf;
  } vec_t;

  fp_mul_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .of        (of),
    .uf        (uf)
  );

  always #5 clk = ~clk;

  // Drives one operation, waits (bounded) for the result, then consumes it.
  task automatic do_op(input logic [11:0] a, input logic [11:0] b,
                       output logic [11:0] zo, output logic o, output logic u,
                       output int lat);
    in_valid = 1'b1;
    x = a;
    y = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x = 12'($urandom);
    y = 12'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    zo = z;
    o  = of;
    u  = uf;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
    n_checks++;
    if (z !== 12'h000 || of !== 1'b0 || uf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out: z=%b of=%b uf=%b, required 0 0 0", z, of, uf);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    vec_t v [0:17] = '{
      '{12'b001101100000, 12'b001111000000, 12'b001101100000, 1'b0, 1'b0},
      '{12'b001101100000, 12'b101111000000, 12'b101101100000, 1'b0, 1'b0},
      '{12'b001101000000, 12'b001111000000, 12'b001101000000, 1'b0, 1'b0},
      '{12'b001111100000, 12'b001111100000, 12'b010000001000, 1'b0, 1'b0},
      '{12'b011101000000, 12'b011101000000, 12'b011111000000, 1'b1, 1'b0},
      '{12'b000001000000, 12'b000001000000, 12'b000000000000, 1'b0, 1'b1},
      '{12'b000000000000, 12'b001111000000, 12'b000000000000, 1'b0, 1'b0},
      '{12'b100000000000, 12'b001111000000, 12'b100000000000, 1'b0, 1'b0},
      '{12'b001111111111, 12'b001111111111, 12'b010000111110, 1'b0, 1'b0},
      '{12'b010111000000, 12'b010111000000, 12'b011111000000, 1'b1, 1'b0},
      '{12'b010111000000, 12'b010110000000, 12'b011110000000, 1'b0, 1'b0},
      '{12'b000111000000, 12'b001000000000, 12'b000000000000, 1'b0, 1'b1},
      '{12'b001000000000, 12'b001000000000, 12'b000001000000, 1'b0, 1'b0},
      '{12'b000111100000, 12'b001000100000, 12'b000001001000, 1'b0, 1'b0},
      '{12'b010111100000, 12'b010110100000, 12'b011111000000, 1'b1, 1'b0},
      '{12'b110111000000, 12'b010111000000, 12'b111111000000, 1'b1, 1'b0},
      '{12'b100001000000, 12'b000001000000, 12'b100000000000, 1'b0, 1'b1},
      '{12'b111110000000, 12'b000000111111, 12'b100000000000, 1'b0, 1'b0}
    };
    logic [11:0] zo;
    logic        o, u;
    int          lat;
    for (int i = 0; i < 18; i++) begin
      do_op(v[i].x, v[i].y, zo, o, u, lat);
      n_checks++;
      if (lat !== 9) begin
        n_fail++;
        $display("FAIL vec%0d_latency: got %0d cycles, required 9", i, lat);
      end
      n_checks++;
      if (zo !== v[i].z || o !== v[i].of || u !== v[i].uf) begin
        n_fail++;
        $display("FAIL vec%0d_result: z=%b of=%b uf=%b, required z=%b of=%b uf=%b",
                 i, zo, o, u, v[i].z, v[i].of, v[i].uf);
      end
    end
  endtask

  task automatic test_backpressure();
    int wait_cyc = 0;
    in_valid = 1'b1;
    x = 12'b001111100000;
    y = 12'b001111100000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    while (!out_valid && wait_cyc < 40) begin
      @(posedge clk);
      #1;
      wait_cyc++;
    end
    n_checks++;
    if (wait_cyc !== 9) begin
      n_fail++;
      $display("FAIL bp_latency: got %0d cycles, required 9", wait_cyc);
    end
    in_valid = 1'b1;
    x = 12'b011101000000;
    y = 12'b011101000000;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || z !== 12'b010000001000 ||
          of !== 1'b0 || uf !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: out_valid=%b in_ready=%b z=%b of=%b uf=%b, required 1 0 010000001000 0 0",
                 c, out_valid, in_ready, z, of, uf);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_consume: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_no_accept: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_abort();
    logic [11:0] zo;
    logic        o, u;
    int          lat;
    logic        seen = 1'b0;
    in_valid = 1'b1;
    x = 12'b001101100000;
    y = 12'b001111000000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || z !== 12'h000) begin
      n_fail++;
      $display("FAIL abort_async: in_ready=%b out_valid=%b z=%b, required 1 0 0", in_ready, out_valid, z);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_result: out_valid seen=%b, required 0", seen);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_op(12'b001111100000, 12'b001111100000, zo, o, u, lat);
    n_checks++;
    if (lat !== 9 || zo !== 12'b010000001000 || o !== 1'b0 || u !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_recover: lat=%0d z=%b of=%b uf=%b, required 9 010000001000 0 0", lat, zo, o, u);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] zo;
    logic        o, u;
    int          lat;
    do_op(12'b001101000000, 12'b001111000000, zo, o, u, lat);
    n_checks++;
    if (lat !== 9 || zo !== 12'b001101000000 || o !== 1'b0 || u !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_first: lat=%0d z=%b of=%b uf=%b, required 9 001101000000 0 0", lat, zo, o, u);
    end
    do_op(12'b110111000000, 12'b010111000000, zo, o, u, lat);
    n_checks++;
    if (lat !== 9 || zo !== 12'b111111000000 || o !== 1'b1 || u !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second: lat=%0d z=%b of=%b uf=%b, required 9 111111000000 1 0", lat, zo, o, u);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_mul_seq.md
FP_MUL_SEQ -- requirements
Module: fp_mul_seq

Interface
REQ-001 SHALL have parameter EXP_W, default 5, exponent field width (3..8).
REQ-002 SHALL have parameter MAN_W, default 6, stored mantissa field width (2..16); derived W = 1+EXP_W+MAN_W (default 12).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operands x, y present.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have ports x, y  input  W  operands, format {sign, biased exponent, mantissa}.
REQ-008 SHALL have port out_valid  output  1  result z/of/uf valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port z  output  W  product.
REQ-011 SHALL have ports of, uf  output  1 each  overflow and underflow flags, qualified by out_valid.

Function
REQ-012 Format SHALL be: bias = 2^(EXP_W-1)-1, hidden leading 1, exponent field 0 means zero (denormals flushed to zero), all-ones exponent reserved for overflow result.
REQ-013 FSM SHALL have states IDLE, MUL, NORM, DONE; in_ready = 1 only in IDLE.
REQ-014 IDLE->MUL on in_valid&&in_ready; x, y captured at that edge, later input changes ignored.
REQ-015 MUL SHALL perform shift-add of the two (MAN_W+1)-bit significands, one partial product per cycle, exactly MAN_W+1 cycles, then ->NORM.
REQ-016 NORM SHALL take one cycle: if product bit 2*MAN_W+1 is set, shift right 1 and increment exponent; mantissa truncated (round toward zero) to MAN_W bits; then ->DONE.
REQ-017 Latency SHALL be fixed at MAN_W+3 cycles from accepting edge to out_valid=1 (9 cycles at default), independent of operand values including zeros.
REQ-018 Sign of z SHALL be x.sign XOR y.sign in all cases, including zero, overflow and underflow results.
REQ-019 Result exponent SHALL be computed as ex+ey-bias(+1 if normalised) in EXP_W+2-bit signed arithmetic with no intermediate wrap.
REQ-020 If result exponent >= 2^EXP_W-1: z = {sign, all-ones, zero mantissa}, of=1, uf=0.
REQ-021 If result exponent <= 0 and neither operand is zero: z = {sign, zeros}, uf=1, of=0.
REQ-022 If either operand has exponent field 0: z = {sign, zeros}, of=0, uf=0.
REQ-023 DONE SHALL hold z, of, uf, out_valid stable until out_valid&&out_ready; at that edge ->IDLE, out_valid=0.
REQ-024 No new operand SHALL be accepted in the same cycle the result is consumed (in_ready rises the following cycle).
REQ-025 of and uf SHALL never be 1 simultaneously.

Reset
REQ-026 rst_n=0 SHALL asynchronously force state IDLE, in_ready=1, out_valid=0, z=0, of=0, uf=0, datapath registers 0.
REQ-027 Reset asserted mid-MUL, NORM or DONE SHALL abort the operation; no result is delivered after deassertion.
REQ-028 First accept after reset deassertion SHALL be possible on the first rising edge with rst_n=1.

Structure
REQ-029 Shared package fp_pkg SHALL hold the FSM state enum, bias function of EXP_W, and flag-encoding constants.
REQ-030 Sub-module fp_shift_add_mul (iterative unsigned significand multiplier, parameter N=MAN_W+1, start/done) SHALL hold the MUL datapath; sign/exponent/normalise/flags stay in fp_mul_seq.

Verification (default EXP_W=5, MAN_W=6)
REQ-031 x=001101100000, y=001111000000 -> after 9 cycles z=001101100000, of=0, uf=0.
REQ-032 x=001101100000, y=101111000000 -> z=101101100000; x=001101000000, y=001111000000 -> z=001101000000.
REQ-033 x=y=001111100000 (1.5*1.5) -> normalisation path, z=010000001000, of=0, uf=0.
REQ-034 x=y=011101000000 -> z=011111000000, of=1; x=y=000001000000 -> z=000000000000, uf=1.
REQ-035 out_ready held 0 for 5 cycles in DONE -> z/flags stable, in_ready=0; new in_valid ignored until result consumed.
REQ-036 rst_n pulsed low in cycle 4 of MUL -> out_valid never asserts for that operation; next operation after reset returns correct result at nominal latency.
